// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the 4-bit ALU slice: the datapath width, the
// op_sel encodings and the packed status-flag bundle that the top level
// registers alongside the result.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Status flags travel together so that the next-state logic and the
  // output register stay in step.
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

  // Flag values after reset: the result is 0, so zero must read as 1.
  localparam alu_flags_t FLAGS_RESET = '{carry: 1'b0, overflow: 1'b0,
                                        zero: 1'b1, negative: 1'b0};

endpackage

// File: rtl/alu_4b_adder.sv
// alu_4b_adder
// Purely combinational ripple-carry adder for the ALU datapath.
// Ports:
//   i_a, i_b     : ALU_W-bit addends (unsigned or two's complement)
//   o_sum        : sum modulo 2**ALU_W
//   o_carry      : carry-out of the most significant bit
//   o_overflow   : signed overflow (operands agree in sign, sum does not)
module alu_4b_adder
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  output logic [ALU_W-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [ALU_W:0] w_c;

  assign w_c[0] = 1'b0;

  // One full adder per bit; the carry chain ripples from bit 0 upward.
  for (genvar gi = 0; gi < ALU_W; gi++) begin : g_bit
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_carry    = w_c[ALU_W];
  assign o_overflow = (i_a[ALU_W-1] == i_b[ALU_W-1]) &&
                      (o_sum[ALU_W-1] != i_a[ALU_W-1]);

endmodule

// File: rtl/alu_4b.sv
// alu_4b
// Registered 4-bit ALU: ADD / AND / OR / XOR with carry, overflow, zero
// and negative flags. A request sampled with in_valid high produces its
// result and a one-cycle out_valid pulse on the following cycle; while
// in_valid is low the result and flags hold.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (wins over in_valid)
//   in_valid  : request strobe
//   A, B      : 4-bit operands
//   op_sel    : 00 ADD, 01 AND, 10 OR, 11 XOR
//   result    : registered result
//   carry     : ADD carry-out, 0 for logic ops
//   overflow  : ADD signed overflow, 0 for logic ops
//   zero      : result == 0
//   negative  : result[3]
//   out_valid : one-cycle pulse per accepted request
module alu_4b
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [1:0]       op_sel,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);

  logic [ALU_W-1:0] w_sum;
  logic             w_add_carry;
  logic             w_add_ovf;
  logic [ALU_W-1:0] w_result;
  alu_flags_t       w_flags;

  logic [ALU_W-1:0] r_result;
  alu_flags_t       r_flags;
  logic             r_valid;

  alu_4b_adder u_adder (
    .i_a        (A),
    .i_b        (B),
    .o_sum      (w_sum),
    .o_carry    (w_add_carry),
    .o_overflow (w_add_ovf)
  );

  // Operation mux plus flag derivation. Carry and overflow only carry
  // meaning for ADD and are forced low for the bitwise ops; zero and
  // negative always reflect the freshly selected result.
  always_comb begin
    w_result         = '0;
    w_flags.carry    = 1'b0;
    w_flags.overflow = 1'b0;
    unique case (op_sel)
      OP_ADD: begin
        w_result         = w_sum;
        w_flags.carry    = w_add_carry;
        w_flags.overflow = w_add_ovf;
      end
      OP_AND:  w_result = A & B;
      OP_OR:   w_result = A | B;
      OP_XOR:  w_result = A ^ B;
      default: w_result = '0;
    endcase
    w_flags.zero     = (w_result == '0);
    w_flags.negative = w_result[ALU_W-1];
  end

  // Output register stage. Reset takes priority, so a request arriving
  // together with rst is simply dropped. Otherwise out_valid mirrors the
  // previous cycle's in_valid and the datapath only loads on a request,
  // which gives the hold-when-idle behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= FLAGS_RESET;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
        r_flags  <= w_flags;
      end
    end
  end

  assign result    = r_result;
  assign carry     = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_alu_4b.sv
// tb_alu_4b
// Scoreboard bench for alu_4b. Each accepted request pushes a
// hand-computed expected response; a monitor on the falling edge pops and
// compares whenever out_valid is high. Reset, hold and drop behaviour
// are checked directly against constants.
module tb_alu_4b;

  typedef struct packed {
    logic [3:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] op_sel;
  logic [3:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       negative;
  logic       out_valid;

  exp_t expQ[$];
  int   passCount  = 0;
  int   checkCount = 0;

  alu_4b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .op_sel    (op_sel),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .out_valid (out_valid)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point so every check is counted the same way.
  task automatic compare(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Compare the full visible output state against constants.
  task automatic checkOutput(input string name, input exp_t e, input logic expValid);
    compare({name, ".result"},    int'(result),    int'(e.res));
    compare({name, ".carry"},     int'(carry),     int'(e.c));
    compare({name, ".overflow"},  int'(overflow),  int'(e.v));
    compare({name, ".zero"},      int'(zero),      int'(e.z));
    compare({name, ".negative"},  int'(negative),  int'(e.n));
    compare({name, ".out_valid"}, int'(out_valid), int'(expValid));
  endtask

  // Drive one request, record its expected response, then clock it in.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] op, input exp_t e);
    A        = a;
    B        = b;
    op_sel   = op;
    in_valid = 1'b1;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding
  // expectation; a pulse with nothing outstanding is itself a failure.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        compare("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        compare("sb.result",   int'(result),   int'(e.res));
        compare("sb.carry",    int'(carry),    int'(e.c));
        compare("sb.overflow", int'(overflow), int'(e.v));
        compare("sb.zero",     int'(zero),     int'(e.z));
        compare("sb.negative", int'(negative), int'(e.n));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam exp_t RST_STATE = '{res: 4'd0, c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    A        = 4'd12;
    B        = 4'd4;
    op_sel   = 2'b00;

    // Reset held two cycles with a request pending: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset", RST_STATE, 1'b0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle", RST_STATE, 1'b0);

    // ADD wrap: 12 + 4 = 16 -> 0 with carry.
    applyStimulus(4'd12, 4'd4, 2'b00, '{res: 4'd0, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});
    compare("add_wrap.out_valid", int'(out_valid), 1);

    // ADD signed overflow: 5 + 3 = 8 (-8 signed).
    applyStimulus(4'd5, 4'd3, 2'b00, '{res: 4'd8, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1});
    applyIdle();
    checkOutput("hold_after_ovf", '{res: 4'd8, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1}, 1'b0);

    // AND back-to-back: out_valid must stay high on all three cycles.
    applyStimulus(4'd15, 4'd10, 2'b01, '{res: 4'd10, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1});
    compare("and0.out_valid", int'(out_valid), 1);
    applyStimulus(4'd5, 4'd3, 2'b01, '{res: 4'd1, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
    compare("and1.out_valid", int'(out_valid), 1);
    applyStimulus(4'd12, 4'd3, 2'b01, '{res: 4'd0, c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0});
    compare("and2.out_valid", int'(out_valid), 1);

    // OR then XOR, then three idle cycles holding the XOR result.
    applyStimulus(4'd12, 4'd3, 2'b10, '{res: 4'd15, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1});
    applyStimulus(4'd5, 4'd5, 2'b11, '{res: 4'd0, c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0});
    for (int i = 0; i < 3; i++) begin
      applyIdle();
      checkOutput("hold_after_xor", RST_STATE, 1'b0);
    end

    // Request followed by reset on the next edge: its pulse is seen by the
    // monitor, then reset clears the result and out_valid.
    applyStimulus(4'd5, 4'd3, 2'b00, '{res: 4'd8, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1});
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_after_req", RST_STATE, 1'b0);
    rst = 1'b0;

    // Request coincident with reset is dropped: load a nonzero result
    // first so the clear is observable.
    applyStimulus(4'd12, 4'd3, 2'b10, '{res: 4'd15, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1});
    A        = 4'd5;
    B        = 4'd3;
    op_sel   = 2'b00;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_with_req", RST_STATE, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("after_dropped_req", RST_STATE, 1'b0);
    end

    // Every expected response must have been consumed by the monitor.
    compare("queue_drained", expQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
